// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Funct3 encodings and responder FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sized RISC-V loads and stores.
// Extends load data, builds the write mask and flags misalignment.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sx;

    assign lane_b = rword[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    // funct3[2] marks the unsigned load variants
    assign sx     = ~funct3[2];

    always_comb begin
        load_val = '0;
        wmask    = '0;
        wword    = '0;
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                load_val = {{24{lane_b[7] & sx}}, lane_b};
                wmask    = 4'b0001 << addr_lo;
                wword    = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                load_val = {{16{lane_h[15] & sx}}, lane_h};
                wmask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            F3_W: begin
                load_val = rword;
                wmask    = 4'b1111;
                wword    = wdata;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with programmable access latency.
// One outstanding transaction; access happens on entry to RESP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam bit         LAT1     = (LATENCY <= 1);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        do_access;
    logic        accept;

    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // In IDLE the live request feeds the datapath so LATENCY=1 works
    logic              cur_write;
    logic [2:0]        cur_f3;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [IDX_W-1:0]  idx;

    assign cur_write = (state_q == IDLE) ? req_write  : wr_q;
    assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    assign idx       = cur_addr[IDX_W+1:2];

    logic [31:0] load_val;
    logic [3:0]  wmask;
    logic [31:0] wword;
    logic        misalign;

    mem_lane_align u_align (
        .funct3   (cur_f3),
        .addr_lo  (cur_addr[1:0]),
        .rword    (mem[idx]),
        .wdata    (cur_wdata),
        .load_val (load_val),
        .wmask    (wmask),
        .wword    (wword),
        .misalign (misalign)
    );

    logic illegal;
    logic range_err;
    logic acc_err;

    assign illegal = cur_write
        ? !(cur_f3 inside {F3_B, F3_H, F3_W})
        : !(cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign range_err =
        cur_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS);
    assign acc_err = illegal | misalign | range_err;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LAT1) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                        cnt_d     = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // The decrement that reaches zero is the access cycle
                if (cnt_q <= 4'd1) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cur_write) ? 32'd0 : load_val;
            end
        end
    end

    logic mem_we;
    assign mem_we = do_access && cur_write && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable access latency. It then performs the sized RISC-V access (byte/half/word, signed/unsigned) on an internal word array and returns the read data and an error flag over a second valid/ready handshake. It sits between the core's data-memory port and the backing storage, replacing the zero-latency data memory once the core stalls on memory.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[ADDR_W-1:2]
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15
- ADDR_W, 32, request address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; 1 only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store (size/sign)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal funct3 or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture write/funct3/addr/wdata, load the countdown with LATENCY-1, and go to WAIT. If LATENCY=1, go directly to RESP.
- WAIT: req_ready=0. Decrement each cycle. At count 0, perform the access and go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are registered and held stable until rsp_ready. On rsp_valid&rsp_ready, return to IDLE.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Little-endian lanes. A byte access uses lane addr[1:0]. A half access uses lanes {addr[1],0} and {addr[1],1}. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores write only the addressed lanes, with the low bytes of req_wdata. Other lanes are preserved.
- Error if any of the following holds:
  - half access with addr[0]=1
  - word access with addr[1:0]≠0
  - illegal funct3
  - word index ≥ DEPTH_WORDS
- On error: no array write, rsp_rdata=0, rsp_err=1.
- Exactly one transaction is outstanding. Requests presented in WAIT/RESP are ignored and must be held by the core.

## Timing
- Reset values: state IDLE, req_ready=1 (after deassert), rsp_valid=0, rsp_rdata=0, rsp_err=0, countdown=0. Array contents are not reset.
- Accept in cycle N gives rsp_valid=1 in cycle N+LATENCY. The store is visible to any request accepted in N+LATENCY+1 or later.
- Best-case throughput is one transaction per LATENCY+1 cycles.
- rsp_ready held low stalls indefinitely in RESP with outputs unchanged.
- Reset asserted in WAIT drops the transaction; an uncommitted store is never written. Reset asserted in RESP drops the response; a store already committed stays in the array.
- Countdown is 4 bits and never wraps; it saturates at 0.

## Structure
- Shared package mem_pkg contains:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - enum resp_state_t {IDLE, WAIT, RESP}
- One sub-module, mem_lane_align. It is purely combinational and takes funct3, addr[1:0], the raw word and wdata. It produces the extended load value, the 4-bit byte-write mask, the lane-shifted write word and the misalign flag.
- The FSM, countdown and array live in data_mem_responder.

## Test plan
- LATENCY=2. Reset, then SW addr 0x10 data 0xDEADBEEF. rsp_valid rises 2 cycles after accept with err=0 and rdata=0. A following LW 0x10 returns 0xDEADBEEF.
- Word 0x10=0x8070F0FF. LB 0x11 returns 0xFFFFFFF0, LBU 0x11 returns 0x000000F0, LH 0x12 returns 0xFFFF8070, LHU 0x12 returns 0x00008070.
- Word 0x20=0x11223344. SB 0x22 data 0xAA, then SH 0x20 data 0xBEEF. LW 0x20 returns 0x11AABEEF.
- Error cases each return err=1, rdata=0, with the array unchanged:
  - LH 0x21
  - SW 0x22
  - load funct3=3'b011
  - SW to word index DEPTH_WORDS
- Hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and rsp_err stay constant, req_ready=0, and a new req_valid is not accepted.
- Assert rst mid-WAIT of SW 0x30 data 0x12345678. rsp_valid=0 immediately and req_ready=1 after release. LW 0x30 returns the pre-reset contents.
